// File: rtl/mac_rx.sv
// Ethernet MAC receive front-end: strips preamble/SFD, streams frame bytes,
// checks CRC-32, length and rxer, and keeps good/bad frame counters.
module mac_rx #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        in_rxc,
   input  logic        in_rstn,
   input  logic        in_rxdv,
   input  logic [7:0]  in_rxd,
   input  logic        in_rxer,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_good,
   output logic        out_bad,
   output logic [10:0] out_len,
   output logic [15:0] out_frames_ok,
   output logic [15:0] out_frames_err
);

   typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;
   localparam logic [10:0] LEN_MIN  = 11'(MIN_LEN);
   localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);
   localparam logic [10:0] LEN_SAT  = 11'h7FF;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [10:0] len_q, len_d;
   logic        err_q, err_d;
   logic [7:0]  hold_q, hold_d;
   logic        hvld_q, hvld_d;
   logic        sofp_q, sofp_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        sof_q, sof_d;
   logic        eof_q, eof_d;
   logic        good_q, good_d;
   logic        bad_q, bad_d;
   logic [10:0] olen_q, olen_d;
   logic [15:0] ok_q, ok_d;
   logic [15:0] ecnt_q, ecnt_d;
   logic        frame_ok;

   assign frame_ok = (crc_q == CRC_RES) && (len_q >= LEN_MIN) &&
                     (len_q <= LEN_MAX) && !err_q;

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      len_d   = len_q;
      err_d   = err_q;
      hold_d  = hold_q;
      hvld_d  = hvld_q;
      sofp_d  = sofp_q;
      data_d  = data_q;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      good_d  = 1'b0;
      bad_d   = 1'b0;
      olen_d  = '0;
      ok_d    = ok_q;
      ecnt_d  = ecnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_rxdv) begin
               if (in_rxd == 8'h55) begin
                  state_d = PRE;
               end else begin
                  state_d = DROP;
                  ecnt_d  = ecnt_q + 16'd1;
               end
            end
         end
         PRE: begin
            if (!in_rxdv) begin
               state_d = IDLE;
               ecnt_d  = ecnt_q + 16'd1;
            end else if (in_rxer) begin
               state_d = DROP;
               ecnt_d  = ecnt_q + 16'd1;
            end else if (in_rxd == 8'hD5) begin
               state_d = DATA;
               crc_d   = CRC_INIT;
               len_d   = '0;
               err_d   = 1'b0;
               hvld_d  = 1'b0;
               sofp_d  = 1'b1;
            end else if (in_rxd != 8'h55) begin
               state_d = DROP;
               ecnt_d  = ecnt_q + 16'd1;
            end
         end
         DATA: begin
            if (in_rxdv) begin
               crc_d  = crc_byte(crc_q, in_rxd);
               len_d  = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
               err_d  = err_q | in_rxer;
               hold_d = in_rxd;
               hvld_d = 1'b1;
               if (hvld_q) begin
                  valid_d = 1'b1;
                  data_d  = hold_q;
                  sof_d   = sofp_q;
                  sofp_d  = 1'b0;
               end
            end else begin
               state_d = IDLE;
               hvld_d  = 1'b0;
               // Hold already covers every byte, so crc/len are final here
               if (hvld_q) begin
                  valid_d = 1'b1;
                  data_d  = hold_q;
                  sof_d   = sofp_q;
                  eof_d   = 1'b1;
                  good_d  = frame_ok;
                  bad_d   = !frame_ok;
                  olen_d  = len_q;
                  if (frame_ok) ok_d   = ok_q + 16'd1;
                  else          ecnt_d = ecnt_q + 16'd1;
               end else begin
                  ecnt_d = ecnt_q + 16'd1;
               end
            end
         end
         DROP: begin
            if (!in_rxdv) state_d = IDLE;
         end
         default: state_d = DROP;
      endcase
   end

   always_ff @(posedge in_rxc or negedge in_rstn) begin
      if (!in_rstn) begin
         state_q <= DROP;
         crc_q   <= CRC_INIT;
         len_q   <= '0;
         err_q   <= 1'b0;
         hold_q  <= '0;
         hvld_q  <= 1'b0;
         sofp_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         good_q  <= 1'b0;
         bad_q   <= 1'b0;
         olen_q  <= '0;
         ok_q    <= '0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         len_q   <= len_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
         hvld_q  <= hvld_d;
         sofp_q  <= sofp_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         olen_q  <= olen_d;
         ok_q    <= ok_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign out_data       = data_q;
   assign out_valid      = valid_q;
   assign out_sof        = sof_q;
   assign out_eof        = eof_q;
   assign out_good       = good_q;
   assign out_bad        = bad_q;
   assign out_len        = olen_q;
   assign out_frames_ok  = ok_q;
   assign out_frames_err = ecnt_q;

endmodule

// File: tb/tb_mac_rx.sv
// Scoreboard bench for mac_rx: directed frames, expected bytes queued at
// stimulus time and checked by an independent output monitor.
module tb_mac_rx;

   logic        clk;
   logic        rst_n;
   logic        rxdv;
   logic [7:0]  rxd;
   logic        rxer;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_eof;
   logic        out_good;
   logic        out_bad;
   logic [10:0] out_len;
   logic [15:0] out_frames_ok;
   logic [15:0] out_frames_err;

   mac_rx dut (
      .in_rxc        (clk),
      .in_rstn       (rst_n),
      .in_rxdv       (rxdv),
      .in_rxd        (rxd),
      .in_rxer       (rxer),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_sof       (out_sof),
      .out_eof       (out_eof),
      .out_good      (out_good),
      .out_bad       (out_bad),
      .out_len       (out_len),
      .out_frames_ok (out_frames_ok),
      .out_frames_err(out_frames_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        sof;
      logic        eof;
      logic        good;
      logic        bad;
      logic [10:0] len;
      logic [15:0] ok;
      logic [15:0] err;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  frm[$];
   logic [31:0] crc_tab[256];
   int          checks = 0;
   int          errors = 0;
   int          exp_ok = 0;
   int          exp_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Table-driven reference CRC used only to generate FCS bytes
   task automatic build_tab();
      logic [31:0] c;
      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         crc_tab[n] = c;
      end
   endtask

   task automatic build_inc(input int n);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(8'(i));
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (frm[i]) c = crc_tab[c[7:0] ^ frm[i]] ^ (c >> 8);
      c = ~c;
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
   endtask

   task automatic put(input logic dv, input logic [7:0] d, input logic er);
      rxdv = dv;
      rxd  = d;
      rxer = er;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int n, input bit good, input bit last);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.d    = frm[i];
         e.sof  = (i == 0);
         e.eof  = last && (i == n - 1);
         e.good = e.eof && good;
         e.bad  = e.eof && !good;
         e.len  = 11'(n);
         e.ok   = 16'(exp_ok);
         e.err  = 16'(exp_err);
         sb.push_back(e);
      end
   endtask

   task automatic send_frame(input bit good, input int er_at, input int gap);
      if (good) exp_ok++;
      else      exp_err++;
      push_exp(frm.size(), good, 1'b1);
      for (int i = 0; i < 7; i++) put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'hD5, 1'b0);
      foreach (frm[i]) put(1'b1, frm[i], (i == er_at));
      for (int i = 0; i < gap; i++) put(1'b0, 8'h00, 1'b0);
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, "_ok"}, 32'(out_frames_ok), 32'(exp_ok));
      chk({nm, "_err"}, 32'(out_frames_err), 32'(exp_err));
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data", 32'(out_data), 32'(e.d));
            chk("sof", 32'(out_sof), 32'(e.sof));
            chk("eof", 32'(out_eof), 32'(e.eof));
            chk("good", 32'(out_good), 32'(e.good));
            chk("bad", 32'(out_bad), 32'(e.bad));
            if (e.eof) begin
               chk("len", 32'(out_len), 32'(e.len));
               chk("eof_ok", 32'(out_frames_ok), 32'(e.ok));
               chk("eof_err", 32'(out_frames_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      build_tab();
      rst_n = 1'b0;
      rxdv  = 1'b1;
      rxd   = 8'h55;
      rxer  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_flags", 32'({out_sof, out_eof, out_good, out_bad}), 32'd0);
      chk("rst_len", 32'(out_len), 32'd0);
      chk_cnt("rst");
      // Released mid-frame: must drop until rxdv falls
      @(negedge clk);
      rst_n = 1'b1;
      put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < 8; i++) put(1'b1, 8'(i + 1), 1'b0);
      put(1'b0, 8'h00, 1'b0);
      put(1'b0, 8'h00, 1'b0);
      chk_cnt("drop_rel");

      build_inc(60);
      add_fcs();
      send_frame(1'b1, -1, 2);
      chk_cnt("good_min");

      build_inc(60);
      add_fcs();
      frm[10] = 8'hFF;
      send_frame(1'b0, -1, 2);
      chk_cnt("corrupt");

      build_inc(56);
      add_fcs();
      send_frame(1'b0, -1, 2);
      chk_cnt("runt");

      build_inc(60);
      add_fcs();
      send_frame(1'b0, 20, 2);
      chk_cnt("rxer");

      put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'h12, 1'b0);
      exp_err++;
      for (int i = 0; i < 5; i++) put(1'b1, 8'h33, 1'b0);
      put(1'b0, 8'h00, 1'b0);
      chk_cnt("bad_pre");
      build_inc(70);
      add_fcs();
      send_frame(1'b1, -1, 2);
      chk_cnt("after_bad_pre");

      frm.delete();
      frm.push_back(8'hAB);
      send_frame(1'b0, -1, 2);
      chk_cnt("one_byte");

      put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'hD5, 1'b0);
      put(1'b0, 8'h00, 1'b0);
      exp_err++;
      put(1'b0, 8'h00, 1'b0);
      chk_cnt("zero_byte");

      build_inc(64);
      add_fcs();
      send_frame(1'b1, -1, 1);
      build_inc(100);
      add_fcs();
      send_frame(1'b1, -1, 2);
      chk_cnt("b2b");

      build_inc(1514);
      add_fcs();
      send_frame(1'b1, -1, 2);
      chk_cnt("max_len");
      build_inc(1515);
      add_fcs();
      send_frame(1'b0, -1, 2);
      chk_cnt("over_max");

      // Reset pulse with byte 30 on the wire; bytes 0..28 already emitted
      build_inc(60);
      add_fcs();
      push_exp(29, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) put(1'b1, 8'h55, 1'b0);
      put(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < 30; i++) put(1'b1, frm[i], 1'b0);
      rxd = frm[30];
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      exp_ok  = 0;
      exp_err = 0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk_cnt("mid_rst");
      chk("mid_rst_drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 31; i < 64; i++) put(1'b1, frm[i], 1'b0);
      put(1'b0, 8'h00, 1'b0);
      put(1'b0, 8'h00, 1'b0);
      chk_cnt("post_rst");

      build_inc(60);
      add_fcs();
      send_frame(1'b1, -1, 2);
      chk_cnt("post_rst_good");

      repeat (4) put(1'b0, 8'h00, 1'b0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
